// File: rtl/alu_unit.sv
// RV32I-style integer ALU: logic, shift, add/sub, set-less-than, with operand/result flags.
// Latency: 1 cycle (combinational datapath, all outputs registered); throughput 1 op/cycle.
// Backpressure: none; every rising edge accepts a new operation and retires the previous one.
module alu_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic [N-1:0] out,
    output logic         overflow,
    output logic         outputs_zero,
    output logic         inputs_equal
);

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0001,
        ALU_OR   = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_ADD  = 4'b1000,
        ALU_SUB  = 4'b1100,
        ALU_SLT  = 4'b1101,
        ALU_SLTU = 4'b1111
    } alu_control_t;

    typedef struct packed {
        logic [N-1:0] res;
        logic         ovf;
        logic         zero;
        logic         eq;
    } alu_rslt_t;

    logic [4:0]   shamt;
    logic [N-1:0] sum_dat;
    logic [N-1:0] diff_dat;
    logic         add_ovf;
    logic         sub_ovf;
    logic         slt_bit;
    logic         sltu_bit;
    alu_rslt_t    nxt_rslt;
    alu_rslt_t    rslt_q;

    assign shamt    = b[4:0];
    assign sum_dat  = a + b;
    assign diff_dat = a - b;
    assign add_ovf  = (a[N-1] == b[N-1]) && (sum_dat[N-1] != a[N-1]);
    assign sub_ovf  = (a[N-1] != b[N-1]) && (diff_dat[N-1] != a[N-1]);
    // Signed compare via the sign bits and the unsigned compare avoids the a-b overflow trap.
    assign sltu_bit = (a < b);
    assign slt_bit  = (a[N-1] != b[N-1]) ? a[N-1] : sltu_bit;

    always_comb begin
        nxt_rslt = '0;
        case (op)
            ALU_AND:  nxt_rslt.res = a & b;
            ALU_OR:   nxt_rslt.res = a | b;
            ALU_XOR:  nxt_rslt.res = a ^ b;
            ALU_SLL:  nxt_rslt.res = a << shamt;
            ALU_SRL:  nxt_rslt.res = a >> shamt;
            ALU_SRA:  nxt_rslt.res = $signed(a) >>> shamt;
            ALU_ADD: begin
                nxt_rslt.res = sum_dat;
                nxt_rslt.ovf = add_ovf;
            end
            ALU_SUB: begin
                nxt_rslt.res = diff_dat;
                nxt_rslt.ovf = sub_ovf;
            end
            ALU_SLT:  nxt_rslt.res = {{(N-1){1'b0}}, slt_bit};
            ALU_SLTU: nxt_rslt.res = {{(N-1){1'b0}}, sltu_bit};
            default:  nxt_rslt.res = '0;
        endcase
        nxt_rslt.zero = (nxt_rslt.res == '0);
        nxt_rslt.eq   = (a == b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rslt_q <= '0;
        end else begin
            rslt_q <= nxt_rslt;
        end
    end

    assign out          = rslt_q.res;
    assign overflow     = rslt_q.ovf;
    assign outputs_zero = rslt_q.zero;
    assign inputs_equal = rslt_q.eq;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors with fixed expectations, then
// back-to-back corner-pair and random vectors scored against an independent model.
module tb_alu_unit;

    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1100;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        logic        eq;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] out;
    logic        overflow;
    logic        outputs_zero;
    logic        inputs_equal;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    alu_unit #(.N(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a),
        .b            (b),
        .op           (op),
        .out          (out),
        .overflow     (overflow),
        .outputs_zero (outputs_zero),
        .inputs_equal (inputs_equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural reference built on 64-bit signed arithmetic and bitwise loops.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic [3:0] mop);
        exp_t   e;
        longint sa;
        longint sb64;
        longint wide;
        int     sh;
        e    = '0;
        sa   = longint'($signed(ma));
        sb64 = longint'($signed(mb));
        sh   = int'(mb[4:0]);
        case (mop)
            OP_AND: e.res = ma & mb;
            OP_OR:  e.res = ma | mb;
            OP_XOR: e.res = ma ^ mb;
            OP_SLL: for (int i = 0; i < 32; i++) e.res[i] = (i >= sh) ? ma[i-sh] : 1'b0;
            OP_SRL: for (int i = 0; i < 32; i++) e.res[i] = (i + sh <= 31) ? ma[i+sh] : 1'b0;
            OP_SRA: for (int i = 0; i < 32; i++) e.res[i] = (i + sh <= 31) ? ma[i+sh] : ma[31];
            OP_ADD: begin
                wide  = sa + sb64;
                e.res = wide[31:0];
                e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            OP_SUB: begin
                wide  = sa - sb64;
                e.res = wide[31:0];
                e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            OP_SLT:  e.res = (sa < sb64) ? 32'd1 : 32'd0;
            OP_SLTU: e.res = ({32'd0, ma} < {32'd0, mb}) ? 32'd1 : 32'd0;
            default: e.res = 32'd0;
        endcase
        e.zero = (e.res == 32'd0);
        e.eq   = (ma == mb);
        return e;
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        exp_t obs;
        @(posedge clk);
        #1;
        vectors++;
        obs = {out, overflow, outputs_zero, inputs_equal};
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL %s: no expected entry queued, observed %h", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed out=%h ovf=%b zero=%b eq=%b, expected out=%h ovf=%b zero=%b eq=%b",
                       tag, obs.res, obs.ovf, obs.zero, obs.eq, e.res, e.ovf, e.zero, e.eq);
            end
        end
    endtask

    task automatic drive(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] iop);
        @(negedge clk);
        a  = ia;
        b  = ib;
        op = iop;
    endtask

    // Directed vector with a hand-derived expected result and overflow.
    task automatic vec(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] iop,
                       input logic [31:0] eres, input logic eovf, input string tag);
        drive(ia, ib, iop);
        sb.push_back(exp_t'{eres, eovf, (eres == 32'd0), (ia == ib)});
        check_out(tag);
    endtask

    task automatic vecm(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] iop, input string tag);
        drive(ia, ib, iop);
        sb.push_back(model(ia, ib, iop));
        check_out(tag);
    endtask

    task automatic check_zero(input string tag);
        exp_t obs;
        vectors++;
        obs = {out, overflow, outputs_zero, inputs_equal};
        assert (obs === exp_t'(0)) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected all-zero outputs", tag, obs);
        end
    endtask

    logic [31:0] corners [5];

    initial begin
        vectors     = 0;
        miscompares = 0;
        corners     = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        rst_n = 1'b0;
        a     = 32'd5;
        b     = 32'd5;
        op    = OP_ADD;

        #2;
        check_zero("reset_async");
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_held");

        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(exp_t'{32'h0000_000A, 1'b0, 1'b0, 1'b1});
        check_out("reset_release_add");

        vec(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 1'b1, "add_ovf");
        vec(32'h8000_0000, 32'h0000_0001, OP_SUB, 32'h7FFF_FFFF, 1'b1, "sub_ovf");
        vec(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1'b0, "add_wrap_zero");
        vec(32'h8000_0001, 32'h0000_0004, OP_SLL, 32'h0000_0010, 1'b0, "sll4");
        vec(32'h8000_0001, 32'h0000_0004, OP_SRL, 32'h0800_0000, 1'b0, "srl4");
        vec(32'h8000_0001, 32'h0000_0004, OP_SRA, 32'hF800_0000, 1'b0, "sra4");
        vec(32'h8000_0001, 32'h0000_0024, OP_SRA, 32'hF800_0000, 1'b0, "sra_hi_ignored");
        vec(32'h8000_0001, 32'h0000_0020, OP_SLL, 32'h8000_0001, 1'b0, "sll_shamt0");
        vec(32'hFFFF_FFFF, 32'h0000_0001, OP_SLT, 32'h0000_0001, 1'b0, "slt_neg");
        vec(32'hFFFF_FFFF, 32'h0000_0001, OP_SLTU, 32'h0000_0000, 1'b0, "sltu_big");
        vec(32'h8000_0000, 32'h7FFF_FFFF, OP_SLT, 32'h0000_0001, 1'b0, "slt_ovf_case");
        vec(32'h8000_0000, 32'h0000_0001, OP_SLT, 32'h0000_0001, 1'b0, "slt_min");
        vec(32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_AND, 32'h00F0_00F0, 1'b0, "and");
        vec(32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_OR,  32'hFFF0_FFF0, 1'b0, "or");
        vec(32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_XOR, 32'hFF00_FF00, 1'b0, "xor");
        vec(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000, 32'h0000_0000, 1'b0, "undef_op0");
        vec(32'h1234_5678, 32'h1234_5678, 4'b1010, 32'h0000_0000, 1'b0, "undef_eq");
        vec(32'h0000_0003, 32'h0000_0003, OP_SUB, 32'h0000_0000, 1'b0, "sub_zero_eq");

        // Asynchronous reset mid-stream, between clock edges.
        drive(32'h0000_0001, 32'h0000_0002, OP_ADD);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset_async");
        @(posedge clk);
        #1;
        check_zero("midreset_held");
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(model(32'h0000_0001, 32'h0000_0002, OP_ADD));
        check_out("midreset_release");

        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                for (int k = 0; k < 16; k++)
                    vecm(corners[i], corners[j], 4'(k), "corner_pair");

        for (int n = 0; n < 60; n++)
            vecm($urandom, (n % 3 == 0) ? 32'($urandom_range(0, 63)) : $urandom,
                 4'($urandom_range(0, 15)), "random");

        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
